// File: rtl/alu_md_if.sv
// Handshake and operand/result bundle between the execute stage and alu_md.
// master drives requests and accepts results; slave is the ALU side.
interface alu_md_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             negative;
    logic             overflow;
    logic             div_by_zero;
    logic             illegal;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero, negative, overflow, div_by_zero, illegal
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero, negative, overflow, div_by_zero, illegal
    );
endinterface

// File: rtl/alu_md.sv
// Handshaked execute-stage ALU with registered results, iterative shift-add multiplier
// and optional restoring divider (built only when ALU_MD_DIV_EN is defined).
module alu_md #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic    CLK,
    input  logic    nRST,
    alu_md_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

    typedef enum logic [3:0] {
        OP_SLL, OP_SRL, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR,
        OP_SLT, OP_SLTU, OP_MUL, OP_MULHU, OP_DIVU, OP_REMU
    } op_e;

    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    state_e             state_q, state_d;
    logic               accept;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               negative_q, negative_d;
    logic               overflow_q, overflow_d;
    logic               dbz_q, dbz_d;
    logic               illegal_q, illegal_d;

    logic               load;
    logic [WIDTH-1:0]   res_new;
    logic               ovf_new;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;
    logic               alu_ill;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
`ifdef ALU_MD_DIV_EN
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;
`endif

    assign accept = bus.in_valid && bus.in_ready;

    // NOTE: reset is synchronous, so it lives inside the clocked block and uses <= like all state.
    always_ff @(posedge CLK) begin
        if (!nRST) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (bus.op == OP_MUL || bus.op == OP_MULHU) state_d = S_MUL;
`ifdef ALU_MD_DIV_EN
                    else if (bus.op == OP_DIVU || bus.op == OP_REMU) state_d = S_DIV;
`endif
                    else state_d = S_DONE;
                end
            end
            S_MUL: if (cnt_q == '0) state_d = S_DONE;
`ifdef ALU_MD_DIV_EN
            S_DIV: if (b_q == '0 || cnt_q == '0) state_d = S_DONE;
`else
            S_DIV: state_d = S_IDLE;
`endif
            S_DONE: if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == S_IDLE);
        bus.out_valid = (state_q == S_DONE);
    end

    // Single-cycle ops; multi-cycle opcodes never take this result when their unit exists.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (bus.op)
            OP_SLL:  alu_res = bus.a << bus.b[SHW-1:0];
            OP_SRL:  alu_res = bus.a >> bus.b[SHW-1:0];
            OP_ADD: begin
                alu_res = bus.a + bus.b;
                alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = bus.a - bus.b;
                alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND:  alu_res = bus.a & bus.b;
            OP_OR:   alu_res = bus.a | bus.b;
            OP_XOR:  alu_res = bus.a ^ bus.b;
            OP_NOR:  alu_res = ~(bus.a | bus.b);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
            default: alu_ill = 1'b1;
        endcase
    end

    // Low half of acc holds the multiplier and shifts out as the product shifts in.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    end

`ifdef ALU_MD_DIV_EN
    // Restoring step: high half is the partial remainder, low half dividend/quotient.
    always_comb begin
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, b_q};
        if (div_diff[WIDTH]) div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        else                 div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
`endif

    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        op_d      = op_q;
        a_d       = a_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        dbz_d     = dbz_q;
        illegal_d = illegal_q;
`ifdef ALU_MD_DIV_EN
        b_d       = b_q;
`endif
        load      = 1'b0;
        res_new   = '0;
        ovf_new   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d      = bus.op;
                    a_d       = bus.a;
                    cnt_d     = CNT_LAST;
                    dbz_d     = 1'b0;
                    illegal_d = 1'b0;
`ifdef ALU_MD_DIV_EN
                    b_d       = bus.b;
`endif
                    if (bus.op == OP_MUL || bus.op == OP_MULHU) begin
                        acc_d = {{WIDTH{1'b0}}, bus.b};
`ifdef ALU_MD_DIV_EN
                    end else if (bus.op == OP_DIVU || bus.op == OP_REMU) begin
                        acc_d = {{WIDTH{1'b0}}, bus.a};
`endif
                    end else begin
                        load      = 1'b1;
                        res_new   = alu_res;
                        ovf_new   = alu_ovf;
                        illegal_d = alu_ill;
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_next;
                if (cnt_q == '0) begin
                    load    = 1'b1;
                    res_new = (op_q == OP_MULHU) ? mul_next[2*WIDTH-1:WIDTH] : mul_next[WIDTH-1:0];
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef ALU_MD_DIV_EN
            S_DIV: begin
                if (b_q == '0) begin
                    load    = 1'b1;
                    dbz_d   = 1'b1;
                    res_new = (op_q == OP_DIVU) ? '1 : a_q;
                end else begin
                    acc_d = div_next;
                    if (cnt_q == '0) begin
                        load    = 1'b1;
                        res_new = (op_q == OP_DIVU) ? div_next[WIDTH-1:0] : div_next[2*WIDTH-1:WIDTH];
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
`endif
            default: ;
        endcase
        result_d   = load ? res_new : result_q;
        zero_d     = load ? (res_new == '0) : zero_q;
        negative_d = load ? res_new[WIDTH-1] : negative_q;
        overflow_d = load ? ovf_new : overflow_q;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            op_q       <= '0;
            a_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
            overflow_q <= 1'b0;
            dbz_q      <= 1'b0;
            illegal_q  <= 1'b0;
`ifdef ALU_MD_DIV_EN
            b_q        <= '0;
`endif
        end else begin
            op_q       <= op_d;
            a_q        <= a_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            negative_q <= negative_d;
            overflow_q <= overflow_d;
            dbz_q      <= dbz_d;
            illegal_q  <= illegal_d;
`ifdef ALU_MD_DIV_EN
            b_q        <= b_d;
`endif
        end
    end

    assign bus.result      = result_q;
    assign bus.zero        = zero_q;
    assign bus.negative    = negative_q;
    assign bus.overflow    = overflow_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md (WIDTH=32): directed corner cases plus random ops
// compared against an arithmetic reference model; follows ALU_MD_DIV_EN like the DUT.
module tb_alu_md;

    localparam int W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    alu_md_if #(.WIDTH(W)) bus ();

    alu_md #(.WIDTH(W)) dut (
        .CLK (clk),
        .nRST(rst_n),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: result, overflow, div-by-zero, illegal and accept-to-valid latency.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ovf, output logic dbz,
                                  output logic ill, output int lat);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      s;
        logic [63:0] p;
        p   = 64'(a) * 64'(b);
        r   = '0;
        ovf = 1'b0;
        dbz = 1'b0;
        ill = 1'b0;
        lat = 1;
        case (op)
            4'd0: r = a << (b % 32);
            4'd1: r = a >> (b % 32);
            4'd2: begin
                s   = sa + sb;
                r   = 32'(s);
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd3: begin
                s   = sa - sb;
                r   = 32'(s);
                ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd4: r = a & b;
            4'd5: r = a | b;
            4'd6: r = a ^ b;
            4'd7: r = ~(a | b);
            4'd8: r = (sa < sb) ? 32'd1 : 32'd0;
            4'd9: r = (a < b) ? 32'd1 : 32'd0;
            4'd10: begin r = p[31:0];  lat = W + 1; end
            4'd11: begin r = p[63:32]; lat = W + 1; end
`ifdef ALU_MD_DIV_EN
            4'd12, 4'd13: begin
                if (b == 0) begin
                    dbz = 1'b1;
                    lat = 2;
                    r   = (op == 4'd12) ? 32'hFFFF_FFFF : a;
                end else begin
                    lat = W + 1;
                    r   = (op == 4'd12) ? a / b : a % b;
                end
            end
`endif
            default: ill = 1'b1;
        endcase
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] er;
        logic        eo, ed, ei;
        int          el;
        int          lat;
        model(op, a, b, er, eo, ed, ei, el);
        check("in_ready_idle", bus.in_ready, 1);
        bus.op        = op;
        bus.a         = a;
        bus.b         = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.op       = 4'($urandom);
        bus.a        = $urandom;
        bus.b        = $urandom;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("latency op%0d", op), 64'(lat), 64'(el));
        check($sformatf("result op%0d a=%0h b=%0h", op, a, b), bus.result, er);
        check($sformatf("flags z/n/v/dz/il op%0d", op),
              {bus.zero, bus.negative, bus.overflow, bus.div_by_zero, bus.illegal},
              {er == 0, er[31], eo, ed, ei});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold valid/ready/result", {bus.out_valid, bus.in_ready, bus.result}, {2'b10, er});
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("release to idle", {bus.in_ready, bus.out_valid}, 2'b10);
        bus.out_ready = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = '0;
        bus.a         = '0;
        bus.b         = '0;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset ready/valid", {bus.in_ready, bus.out_valid}, 2'b10);
        check("reset result", bus.result, 0);
        check("reset flags", {bus.zero, bus.negative, bus.overflow, bus.div_by_zero, bus.illegal}, 0);

        run_op(4'd2,  32'h7FFF_FFFF, 32'h1, 0);
        check("add ovf result const", bus.result, 32'h8000_0000);
        run_op(4'd3,  32'h8000_0000, 32'h1, 0);
        run_op(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(4'd12, 32'd100, 32'd7, 0);
        run_op(4'd13, 32'd100, 32'd7, 0);
        run_op(4'd12, 32'd100, 32'd0, 0);
        run_op(4'd13, 32'd100, 32'd0, 0);
        run_op(4'd8,  32'hFFFF_FFFF, 32'h1, 10);
        run_op(4'd15, 32'h1234, 32'h5678, 0);
        run_op(4'd14, 32'hFFFF_FFFF, 32'h1, 0);
        run_op(4'd0,  32'h1, 32'h23, 0);
        run_op(4'd1,  32'h8000_0000, 32'h3F, 0);

        // Abort a multiply with a reset pulse part-way through.
        bus.op       = 4'd10;
        bus.a        = 32'hFFFF_FFFF;
        bus.b        = 32'hFFFF_FFFF;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort ready/valid", {bus.in_ready, bus.out_valid}, 2'b10);
        check("abort result", bus.result, 0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        check("abort no out_valid", 64'(seen), 0);
        run_op(4'd2, 32'd2, 32'd3, 0);

        for (int i = 0; i < 60; i++) begin
            run_op(4'($urandom_range(0, 15)), pick(), pick(), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
